// File: rtl/arith_sequencer.sv
// rtl/arith_sequencer.sv - key-launched operand latch, start pulse and watchdog for the 8-bit arithmetic unit
// Optional key debouncer: define ARITH_SEQ_DEBOUNCE_EN.
module arith_sequencer #(
  parameter int WIDTH      = 8,
  parameter int OPW        = 5,
  parameter int TIMEOUT    = 255,
  parameter int DEB_CYCLES = 16
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw_a,
  input  logic [WIDTH-1:0] sw_b,
  input  logic [OPW-1:0]   sw_sel,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [OPW-1:0]   au_sel,
  output logic             au_start,
  input  logic             au_done,
  input  logic [WIDTH-1:0] au_hi,
  input  logic [WIDTH-1:0] au_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  // Last legal watchdog value; WAIT lasts at most TIMEOUT cycles.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        key_meta;
  logic        key_s;
  logic        press;
  logic [15:0] timer;
  logic        load_ops;
  logic        capture;
  logic        timeout_hit;

  // Two-flop synchroniser for the asynchronous key; idles at released (1).
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
    end
  end

`ifdef ARITH_SEQ_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt;
  logic          key_acc;
  logic          key_acc_q;

  // Accept a new key level only after it has differed for DEB_CYCLES cycles in a row.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      key_acc <= 1'b1;
    end else if (key_s == key_acc) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      key_acc <= key_s;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Registered copy of the accepted level for falling-edge detection.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_acc_q <= 1'b1;
    end else begin
      key_acc_q <= key_acc;
    end
  end

  assign press = key_acc_q & ~key_acc;
`else
  logic key_q;

  // Registered copy of the synchronised key for falling-edge detection.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 1'b1;
    end else begin
      key_q <= key_s;
    end
  end

  assign press = key_q & ~key_s;
`endif

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath strobes; presses outside IDLE fall through unused.
  always_comb begin
    state_next  = state;
    load_ops    = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (press) begin
          load_ops   = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (au_done) begin
          capture    = 1'b1;
          state_next = S_IDLE;
        end else if (timer == TIMER_LAST) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_LAUNCH) || (state == S_WAIT);

  // Watchdog: cleared in LAUNCH, counts WAIT cycles without completion.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == S_LAUNCH) begin
      timer <= '0;
    end else if ((state == S_WAIT) && !capture && !timeout_hit) begin
      timer <= timer + 16'd1;
    end
  end

  // Start pulse is a flop so it is high for exactly the LAUNCH cycle.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      au_start <= 1'b0;
    end else begin
      au_start <= load_ops;
    end
  end

  // Operand freeze on launch; later switch changes are ignored.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      au_a   <= '0;
      au_b   <= '0;
      au_sel <= '0;
    end else if (load_ops) begin
      au_a   <= sw_a;
      au_b   <= sw_b;
      au_sel <= sw_sel;
    end
  end

  // Result hold, sticky status flags and completion counter.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      res_hi   <= '0;
      res_lo   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      op_count <= '0;
    end else if (load_ops) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else if (capture) begin
      res_hi   <= au_hi;
      res_lo   <= au_lo;
      done     <= 1'b1;
      op_count <= op_count + 8'd1;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/arith_sequencer.md
Name: arith_sequencer

Overview:
- Controller between the board inputs (switches, start key) and the 8-bit arithmetic unit that produces hi/lo.
- Synchronises the raw active-low start key and turns each press into one launch.
- On each launch it freezes operands and operation select, issues a one-cycle start pulse, waits for completion with a watchdog, and holds the result for the 7-segment display path.
- Reports busy, done and error status for the LEDs.

Parameters:
- WIDTH, 8: operand and result half width.
- OPW, 5: operation select width, matching the oper_t encoding.
- TIMEOUT, 255: maximum WAIT cycles before error; legal range 1..2^16-1.
- DEB_CYCLES, 16: debounce stability window in cycles; used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_n  in  1  raw start key, active low, asynchronous to CLOCK_50.
- sw_a  in  WIDTH  operand a from switches.
- sw_b  in  WIDTH  operand b from switches.
- sw_sel  in  OPW  operation select from switches.
- au_a  out  WIDTH  latched operand a to the arithmetic unit.
- au_b  out  WIDTH  latched operand b to the arithmetic unit.
- au_sel  out  OPW  latched operation select to the arithmetic unit.
- au_start  out  1  one-cycle launch pulse.
- au_done  in  1  completion strobe from the arithmetic unit; hi/lo valid while high.
- au_hi  in  WIDTH  arithmetic unit upper result.
- au_lo  in  WIDTH  arithmetic unit lower result.
- res_hi  out  WIDTH  held upper result.
- res_lo  out  WIDTH  held lower result.
- busy  out  1  high in LAUNCH and WAIT.
- done  out  1  sticky: last operation completed.
- err  out  1  sticky: last operation timed out.
- op_count  out  8  count of completed operations; wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - au_a, au_b, au_sel, res_hi, res_lo, op_count = 0.
  - au_start, busy, done, err = 0.
  - FSM = IDLE; watchdog timer = 0.
  - Synchroniser flops = 1 (key released).
- Reset mid-operation aborts immediately. No result is captured and op_count is unchanged.
- Input conditioning: key_n passes through a 2-flop synchroniser giving key_s. A press is the key_s 1->0 transition, detected with a registered copy of key_s. Holding the key generates exactly one press.
- FSM states:
  - IDLE:
    - busy = 0.
    - On press: au_a<=sw_a, au_b<=sw_b, au_sel<=sw_sel; done<=0, err<=0; go to LAUNCH.
  - LAUNCH:
    - au_start = 1 for exactly this one cycle; busy = 1; timer<=0.
    - Always goes to WAIT next cycle.
  - WAIT:
    - busy = 1.
    - If au_done: res_hi<=au_hi, res_lo<=au_lo, done<=1, op_count<=op_count+1 (255 wraps to 0); go to IDLE.
    - Else if timer == TIMEOUT-1: err<=1, res_* unchanged, op_count unchanged; go to IDLE.
    - Else: timer<=timer+1.
- Latency:
  - Press detected at cycle N; au_start high at N+1.
  - au_done is sampled from N+2.
  - res_* and done update one cycle after au_done is sampled high.
- Boundary rules:
  - A press during LAUNCH or WAIT is ignored and not queued.
  - au_done in IDLE or LAUNCH is ignored.
  - au_done and timeout in the same cycle: completion wins, err stays 0.
  - sw_* changes after the latch do not affect au_*.
  - au_start is registered (glitch-free) and never high on two consecutive cycles.

Optional Feature:
- Macro: ARITH_SEQ_DEBOUNCE_EN.
- Defined: key_s feeds a debouncer.
  - The accepted key level changes only after key_s holds a new value for DEB_CYCLES consecutive cycles.
  - Press = accepted level 1->0.
  - Bounces shorter than DEB_CYCLES produce no press.
  - The debounce counter resets to 0; the accepted level resets to 1.
- Undefined: press = raw key_s falling edge. No debounce logic or counter is instantiated; DEB_CYCLES is unused.

Test Plan:
- Reset mid-WAIT: press with a=0x03 b=0x05, assert rst_n low during WAIT -> all outputs 0, FSM IDLE, op_count=0; a subsequent au_done pulse is ignored.
- Basic op: sw_a=0x12, sw_b=0x34, sw_sel=5'h01, press key_n. Required:
  - au_start high exactly 1 cycle, 3 cycles after the key_n fall.
  - au_a=0x12, au_b=0x34.
  - Return au_done with hi=0x03, lo=0xA8 -> next cycle res_hi=0x03, res_lo=0xA8, done=1, busy=0, op_count=1.
- Timeout: TIMEOUT=4, never assert au_done -> err=1 after 4 WAIT cycles, done=0, res_* held, op_count unchanged. Next press clears err.
- Busy lockout and freeze: press, change sw_a to 0xFF and press again during WAIT -> no second au_start, au_a stays at its latched value. au_done with timeout in the same cycle -> done=1, err=0.
- Wrap: 256 completed operations -> op_count returns to 0x00.
- With ARITH_SEQ_DEBOUNCE_EN, DEB_CYCLES=16: 5-cycle bounce pulses -> no au_start; a 20-cycle stable low -> exactly one au_start.
